i2c_sensor_poller: RTL and testbench

//  Upstream command sequencer for the I2C device core. Periodically (or on trigger) sets a

---
 rtl/i2c_sensor_poller.sv | 167 ++++++++++++++++
 tb/tb_i2c_sensor_poller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sensor_poller.sv
// rtl/i2c_sensor_poller.sv - periodic/triggered I2C register-burst reader feeding a packed sample word
module i2c_sensor_poller #(
    parameter logic [6:0] DEV_ADDR    = 7'h38,
    parameter logic [7:0] REG_ADDR    = 8'h00,
    parameter int         NUM_BYTES   = 2,
    parameter int         POLL_PERIOD = 100000,
    parameter int         TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   trigger,
    output logic                   i2c_start,
    output logic [6:0]             i2c_addr,
    output logic                   i2c_write_en,
    output logic [7:0]             i2c_write_data,
    input  logic                   i2c_busy,
    input  logic [7:0]             i2c_read_data,
    input  logic                   i2c_read_valid,
    input  logic                   i2c_detected,
    output logic [8*NUM_BYTES-1:0] sample_data,
    output logic                   sample_valid,
    output logic                   poll_busy,
    output logic                   err_nodev,
    output logic                   err_timeout
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int TW = $clog2(POLL_PERIOD);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] PP_LAST  = TW'(POLL_PERIOD - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [1:0]    LAST_IDX = 2'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, CHECK, PTR_ISSUE, PTR_WAIT, RD_ISSUE, RD_WAIT, DONE, ERROR
    } state_t;

    state_t          state, next_state;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   tcnt;
    logic [1:0]      idx;
    logic [W-1:0]    asm_q, asm_next;
    logic            seen_busy, got_byte, got_any, rd_take;
    logic            start_poll, waiting, tmo, nodev_cause, byte_done;

    assign i2c_addr  = DEV_ADDR;
    assign poll_busy = (state != IDLE);

    // Bytes shift in at the bottom, so the first byte read ends up in the MSBs.
    always_comb begin
        waiting  = (state == PTR_ISSUE) || (state == PTR_WAIT) ||
                   (state == RD_ISSUE)  || (state == RD_WAIT);
        tmo      = waiting && (tcnt == TO_LAST);
        rd_take  = (state == RD_WAIT) && i2c_read_valid && !got_byte;
        got_any  = got_byte || rd_take;
        asm_next = rd_take ? W'({asm_q, i2c_read_data}) : asm_q;
    end

    always_comb begin
        next_state     = state;
        start_poll     = 1'b0;
        i2c_start      = 1'b0;
        i2c_write_en   = 1'b0;
        i2c_write_data = 8'h00;
        nodev_cause    = 1'b0;
        byte_done      = 1'b0;
        case (state)
            IDLE: begin
                if (trigger || (enable && timer == PP_LAST)) begin
                    start_poll = 1'b1;
                    next_state = CHECK;
                end
            end
            CHECK: begin
                nodev_cause = !i2c_detected;
                next_state  = i2c_detected ? PTR_ISSUE : ERROR;
            end
            PTR_ISSUE: begin
                i2c_write_en   = 1'b1;
                i2c_write_data = REG_ADDR;
                if (tmo) begin
                    next_state = ERROR;
                end else if (!i2c_busy) begin
                    i2c_start  = 1'b1;
                    next_state = PTR_WAIT;
                end
            end
            PTR_WAIT: begin
                if (seen_busy && !i2c_busy) next_state = RD_ISSUE;
                else if (tmo)               next_state = ERROR;
            end
            RD_ISSUE: begin
                if (tmo) begin
                    next_state = ERROR;
                end else if (!i2c_busy) begin
                    i2c_start  = 1'b1;
                    next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // A transaction that finishes without delivering a byte counts as a stall.
                if (seen_busy && !i2c_busy) begin
                    if (!got_any) begin
                        next_state = ERROR;
                    end else if (idx == LAST_IDX) begin
                        next_state = DONE;
                    end else begin
                        byte_done  = 1'b1;
                        next_state = RD_ISSUE;
                    end
                end else if (tmo) begin
                    next_state = ERROR;
                end
            end
            DONE:    next_state = IDLE;
            ERROR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            timer        <= '0;
            tcnt         <= '0;
            idx          <= '0;
            asm_q        <= '0;
            seen_busy    <= 1'b0;
            got_byte     <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            err_nodev    <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                tcnt      <= '0;
                seen_busy <= 1'b0;
                got_byte  <= 1'b0;
            end else begin
                if (waiting) tcnt <= tcnt + 1'b1;
                seen_busy <= seen_busy | i2c_busy;
                got_byte  <= got_any;
            end

            asm_q <= start_poll ? '0 : asm_next;
            if (start_poll)     idx <= '0;
            else if (byte_done) idx <= idx + 1'b1;

            // Period is measured in idle time: the timer only advances while waiting in IDLE.
            if (start_poll || !enable) timer <= '0;
            else if (state == IDLE)    timer <= timer + 1'b1;

            sample_valid <= (next_state == DONE);
            if (next_state == DONE) begin
                sample_data <= asm_next;
                err_nodev   <= 1'b0;
                err_timeout <= 1'b0;
            end else if (next_state == ERROR) begin
                err_nodev   <= nodev_cause;
                err_timeout <= !nodev_cause;
            end
        end
    end

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// tb/tb_i2c_sensor_poller.sv - table-driven bench for i2c_sensor_poller with a behavioural core model
module tb_i2c_sensor_poller;

    localparam int NB      = 2;
    localparam int PP      = 64;
    localparam int TO      = 100;
    localparam int BUSYLEN = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic           trigger = 1'b0;
    logic           i2c_start;
    logic [6:0]     i2c_addr;
    logic           i2c_write_en;
    logic [7:0]     i2c_write_data;
    logic           i2c_busy;
    logic [7:0]     i2c_read_data;
    logic           i2c_read_valid;
    logic           i2c_detected = 1'b1;
    logic [8*NB-1:0] sample_data;
    logic           sample_valid;
    logic           poll_busy;
    logic           err_nodev;
    logic           err_timeout;

    always #5 clk = ~clk;

    i2c_sensor_poller #(
        .DEV_ADDR(7'h38), .REG_ADDR(8'h00), .NUM_BYTES(NB),
        .POLL_PERIOD(PP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
        .i2c_start(i2c_start), .i2c_addr(i2c_addr), .i2c_write_en(i2c_write_en),
        .i2c_write_data(i2c_write_data), .i2c_busy(i2c_busy),
        .i2c_read_data(i2c_read_data), .i2c_read_valid(i2c_read_valid),
        .i2c_detected(i2c_detected), .sample_data(sample_data),
        .sample_valid(sample_valid), .poll_busy(poll_busy),
        .err_nodev(err_nodev), .err_timeout(err_timeout)
    );

    // Core model: busy rises one cycle after start, stays high BUSYLEN cycles,
    // read data strobes on the first low cycle.
    logic       mbusy = 1'b0, hold_busy = 1'b0, core_dead = 1'b0;
    logic       pend = 1'b0, cur_rd = 1'b0, rv = 1'b0;
    logic [7:0] rdd = 8'h00, last_wd = 8'hEE;
    logic [7:0] rd_b [2];
    int         bcnt = 0, nstart = 0, nwrite = 0, nread = 0, bad_start = 0;
    logic [1:0] rd_i = 2'd0;

    assign i2c_busy       = mbusy | hold_busy;
    assign i2c_read_data  = rdd;
    assign i2c_read_valid = rv;

    always @(posedge clk) begin
        rv <= 1'b0;
        if (i2c_start) begin
            nstart <= nstart + 1;
            if (i2c_busy) bad_start <= bad_start + 1;
            if (i2c_write_en) begin
                nwrite  <= nwrite + 1;
                last_wd <= i2c_write_data;
                rd_i    <= 2'd0;
            end else begin
                nread <= nread + 1;
            end
        end
        if (pend) begin
            pend  <= 1'b0;
            mbusy <= 1'b1;
            bcnt  <= BUSYLEN;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
                mbusy <= 1'b0;
                if (cur_rd) begin
                    rv   <= 1'b1;
                    rdd  <= rd_b[rd_i[0]];
                    rd_i <= rd_i + 2'd1;
                end
            end
        end else if (i2c_start && !core_dead) begin
            pend   <= 1'b1;
            cur_rd <= !i2c_write_en;
        end
    end

    int chk_cnt = 0, pass_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_poll(output int len, output int svc);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        len = 0;
        svc = 0;
        while (poll_busy && len < 1000) begin
            if (sample_valid) svc++;
            len++;
            tick();
        end
    endtask

    typedef struct {
        logic        det;
        logic [7:0]  b0, b1;
        logic [15:0] exp_data;
        logic        exp_nodev, exp_to;
        int          exp_starts, exp_valid, exp_len;
    } vec_t;

    vec_t vt [6];

    initial begin
        int len, svc, s0, n;

        vt[0] = '{1'b1, 8'hAB, 8'hCD, 16'hABCD, 1'b0, 1'b0, 3, 1, 26};
        vt[1] = '{1'b0, 8'h11, 8'h22, 16'hABCD, 1'b1, 1'b0, 0, 0, 2};
        vt[2] = '{1'b1, 8'h12, 8'h34, 16'h1234, 1'b0, 1'b0, 3, 1, 26};
        vt[3] = '{1'b1, 8'hFF, 8'h00, 16'hFF00, 1'b0, 1'b0, 3, 1, 26};
        vt[4] = '{1'b0, 8'h99, 8'h88, 16'hFF00, 1'b1, 1'b0, 0, 0, 2};
        vt[5] = '{1'b1, 8'hAB, 8'hCD, 16'hABCD, 1'b0, 1'b0, 3, 1, 26};
        rd_b[0] = 8'h00;
        rd_b[1] = 8'h00;

        repeat (3) tick();
        chk("rst_addr", 32'(i2c_addr), 32'h38);
        chk("rst_ctrl", {26'd0, poll_busy, i2c_start, sample_valid, err_nodev, err_timeout, i2c_write_en}, 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_wdata", 32'(i2c_write_data), 32'd0);
        rst = 1'b1;
        repeat (2) tick();
        chk("idle_busy", 32'(poll_busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            i2c_detected = vt[i].det;
            rd_b[0] = vt[i].b0;
            rd_b[1] = vt[i].b1;
            s0 = nstart;
            run_poll(len, svc);
            chk($sformatf("v%0d_len", i), 32'(len), 32'(vt[i].exp_len));
            chk($sformatf("v%0d_valid_cnt", i), 32'(svc), 32'(vt[i].exp_valid));
            chk($sformatf("v%0d_data", i), 32'(sample_data), 32'(vt[i].exp_data));
            chk($sformatf("v%0d_nodev", i), 32'(err_nodev), 32'(vt[i].exp_nodev));
            chk($sformatf("v%0d_timeout", i), 32'(err_timeout), 32'(vt[i].exp_to));
            chk($sformatf("v%0d_starts", i), 32'(nstart - s0), 32'(vt[i].exp_starts));
            if (vt[i].det) chk($sformatf("v%0d_wdata", i), 32'(last_wd), 32'h00);
            repeat (3) tick();
        end

        // Stalled core: start accepted but busy never rises.
        i2c_detected = 1'b1;
        core_dead = 1'b1;
        s0 = nstart;
        run_poll(len, svc);
        chk("to_len", 32'(len), 32'(TO + 3));
        chk("to_flags", {30'd0, err_nodev, err_timeout}, 32'd1);
        chk("to_data_kept", 32'(sample_data), 32'hABCD);
        chk("to_valid_cnt", 32'(svc), 32'd0);
        chk("to_starts", 32'(nstart - s0), 32'd1);
        core_dead = 1'b0;
        repeat (3) tick();

        // Periodic polling: 64 idle cycles between polls, mid-poll trigger ignored.
        enable = 1'b1;
        n = 0;
        while (!poll_busy && n < 200) begin n++; tick(); end
        n = 0;
        while (poll_busy && n < 1000) begin n++; tick(); end
        n = 0;
        while (!poll_busy && n < 200) begin n++; tick(); end
        chk("per_gap1", 32'(n), 32'(PP));
        s0 = nstart;
        repeat (5) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        n = 0;
        while (poll_busy && n < 1000) begin n++; tick(); end
        chk("per_starts", 32'(nstart - s0), 32'd3);
        n = 0;
        while (!poll_busy && n < 200) begin n++; tick(); end
        chk("per_gap2", 32'(n), 32'(PP));
        enable = 1'b0;
        n = 0;
        while (poll_busy && n < 1000) begin n++; tick(); end
        repeat (3) tick();

        // Reset during RD_WAIT of the second byte.
        rd_b[0] = 8'h55;
        rd_b[1] = 8'h66;
        s0 = nread;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        n = 0;
        while ((nread - s0) < 2 && n < 200) begin n++; tick(); end
        chk("mid_reached_rd1", 32'(nread - s0), 32'd2);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {26'd0, poll_busy, i2c_start, sample_valid, err_nodev, err_timeout, i2c_write_en}, 32'd0);
        chk("mid_rst_data", 32'(sample_data), 32'd0);
        chk("mid_rst_addr", 32'(i2c_addr), 32'h38);
        tick();
        rst = 1'b1;
        repeat (12) tick();
        rd_b[0] = 8'h12;
        rd_b[1] = 8'h34;
        run_poll(len, svc);
        chk("post_rst_data", 32'(sample_data), 32'h1234);
        chk("post_rst_len", 32'(len), 32'd26);
        chk("post_rst_flags", {30'd0, err_nodev, err_timeout}, 32'd0);
        repeat (3) tick();

        // Busy already high at trigger: start held back until it drops.
        hold_busy = 1'b1;
        s0 = nstart;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (20) tick();
        chk("hold_no_start", 32'(nstart - s0), 32'd0);
        chk("hold_poll_busy", 32'(poll_busy), 32'd1);
        hold_busy = 1'b0;
        svc = 0;
        n = 0;
        while (poll_busy && n < 1000) begin
            if (sample_valid) svc++;
            n++;
            tick();
        end
        chk("hold_starts", 32'(nstart - s0), 32'd3);
        chk("hold_valid_cnt", 32'(svc), 32'd1);
        chk("hold_data", 32'(sample_data), 32'h1234);
        chk("start_while_busy", 32'(bad_start), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
